// File: rtl/fila.sv
`default_nettype none
// ============================================================================
// Module   : fila
// Purpose  : 8 x 8-bit synchronous FIFO with registered output word and
//            registered occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module fila #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              enqueue_in,
    input  logic              dequeue_in,
    output logic [DATA_W-1:0] data_out,
    output logic [LEN_W-1:0]  len_out
);

    localparam int               c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_W-1:0] c_FULL  = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] c_ONE   = LEN_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [LEN_W-1:0]   r_len;
    logic [DATA_W-1:0]  r_data_out;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_len == '0);
    assign w_full    = (r_len == c_FULL);
    assign w_do_pop  = dequeue_in && !w_empty;
    // A full queue still accepts a push when the same edge frees a slot.
    assign w_do_push = enqueue_in && (!w_full || w_do_pop);

    always_ff @(posedge clk_10KHz) begin
        if (w_do_push) begin
            r_mem[r_tail] <= data_in;
        end
    end

    always_ff @(posedge clk_10KHz or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_len      <= '0;
            r_data_out <= '0;
        end else begin
            if (w_do_pop) begin
                r_data_out <= r_mem[r_head];
                r_head     <= r_head + c_PTR_ONE;
            end
            if (w_do_push) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_len <= r_len + c_ONE;
                2'b01:   r_len <= r_len - c_ONE;
                default: r_len <= r_len;
            endcase
        end
    end

    assign data_out = r_data_out;
    assign len_out  = r_len;

endmodule
`default_nettype wire

// File: tb/tb_fila.sv
`default_nettype none
`timescale 1us/1ns
// ============================================================================
// Module   : tb_fila
// Purpose  : Randomized and directed self-checking bench for fila against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fila;

    localparam int c_DEPTH = 8;

    logic       clk_10KHz = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       enqueue_in;
    logic       dequeue_in;
    logic [7:0] data_out;
    logic [7:0] len_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_queue [$];
    logic [7:0] m_out;

    always #50 clk_10KHz = ~clk_10KHz;

    fila #(.DATA_W(8), .DEPTH(c_DEPTH), .LEN_W(8)) u_dut (
        .clk_10KHz  (clk_10KHz),
        .reset      (reset),
        .data_in    (data_in),
        .enqueue_in (enqueue_in),
        .dequeue_in (dequeue_in),
        .data_out   (data_out),
        .len_out    (len_out)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: pop first (if anything is stored), then push if room.
    task automatic model_edge(input logic en, input logic de, input logic [7:0] d);
        if (de && m_queue.size() > 0) begin
            m_out = m_queue.pop_front();
        end
        if (en && m_queue.size() < c_DEPTH) begin
            m_queue.push_back(d);
        end
    endtask

    task automatic step(input logic en, input logic de, input logic [7:0] d, input string tag);
        enqueue_in = en;
        dequeue_in = de;
        data_in    = d;
        @(posedge clk_10KHz);
        if (reset) model_edge(en, de, d);
        #1;
        check({tag, " len"}, {8'h00, len_out}, 16'(m_queue.size()));
        check({tag, " out"}, {8'h00, data_out}, {8'h00, m_out});
    endtask

    initial begin
        m_out      = 8'h00;
        reset      = 1'b0;
        enqueue_in = 1'($urandom_range(0, 1));
        dequeue_in = 1'($urandom_range(0, 1));
        data_in    = 8'($urandom);

        repeat (2) begin
            @(posedge clk_10KHz);
            #1;
            enqueue_in = 1'($urandom_range(0, 1));
            dequeue_in = 1'($urandom_range(0, 1));
            data_in    = 8'($urandom);
        end
        check("reset len", {8'h00, len_out}, 16'h0000);
        check("reset out", {8'h00, data_out}, 16'h0000);

        reset = 1'b1;
        step(1'b0, 1'b0, 8'($urandom), "idle after reset");

        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 1'b0, 8'(i * 8'h11), "fill");
        end
        check("full len", {8'h00, len_out}, 16'h0008);

        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 8'($urandom), "drain");
        end
        check("underflow hold", {8'h00, data_out}, 16'h0088);

        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), "wrap enq A");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'($urandom), "wrap deq");
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'hB0 + i), "wrap enq B");
        check("wrap full", {8'h00, len_out}, 16'h0008);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'($urandom), "wrap drain");
        check("wrap last", {8'h00, data_out}, 16'h00B5);

        step(1'b1, 1'b0, 8'h01, "simul pre");
        step(1'b1, 1'b0, 8'h02, "simul pre");
        step(1'b1, 1'b1, 8'h03, "simul both");
        check("simul out", {8'h00, data_out}, 16'h0001);
        step(1'b0, 1'b1, 8'h00, "simul drain");
        step(1'b0, 1'b1, 8'h00, "simul drain");
        check("simul tail", {8'h00, data_out}, 16'h0003);
        step(1'b1, 1'b1, 8'h55, "both on empty");
        check("both empty len", {8'h00, len_out}, 16'h0001);
        step(1'b0, 1'b1, 8'h00, "both empty drain");

        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom), "full both pre");
        step(1'b1, 1'b1, 8'hEE, "full both");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, "full both drain");

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), "pre async");
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        #20;
        reset = 1'b0;
        #1;
        check("async len", {8'h00, len_out}, 16'h0000);
        check("async out", {8'h00, data_out}, 16'h0000);
        m_queue.delete();
        m_out = 8'h00;
        @(posedge clk_10KHz);
        #20;
        reset = 1'b1;
        step(1'b1, 1'b0, 8'h42, "post async enq");
        step(1'b0, 1'b1, 8'h00, "post async deq");
        check("post async out", {8'h00, data_out}, 16'h0042);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                 8'($urandom), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fila.md
Name: fila

Overview:
- Synchronous FIFO queue: 8 entries of 8-bit data, with occupancy count output.
- Sits between a byte producer and a byte consumer in the 10 kHz clock domain.
- Requests are level-sensitive: one operation per clock edge while a request is high.
- Dequeued byte is presented on a registered output.

Parameters:
- DATA_W, 8, width of each stored word and of data_in/data_out.
- DEPTH, 8, number of storage entries; power of two, at most 255.
- LEN_W, 8, width of len_out; must hold values 0..DEPTH.

Ports:
- clk_10KHz  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  8  word written on enqueue.
- enqueue_in  input  1  level request: push data_in on each rising edge while high.
- dequeue_in  input  1  level request: pop head on each rising edge while high.
- data_out  output  8  registered; last dequeued word.
- len_out  output  8  registered; current number of stored entries (0..8).

Behaviour:
- Reset (reset=0, asynchronous):
  - len_out=0, data_out=0x00.
  - Head and tail pointers = 0.
  - Storage contents do not need to be cleared.
  - Reset asserted mid-operation aborts the operation immediately; contents are discarded.
- Storage and pointers:
  - Circular buffer with 3-bit head (read) and tail (write) pointers.
  - Pointers wrap modulo DEPTH (7 -> 0).
  - Occupancy counter has range 0..8; len_out is this counter.
- Enqueue only (enqueue_in=1, dequeue_in=0) on a rising edge:
  - If len<8: mem[tail]<=data_in, tail++, len++.
  - If len==8 (full): request ignored; no state change, no error flag.
- Dequeue only (dequeue_in=1, enqueue_in=0) on a rising edge:
  - If len>0: data_out<=mem[head], head++, len--.
  - If len==0 (empty): request ignored; data_out holds its previous value.
- Both high on the same edge:
  - If 0<len<8: pop head to data_out and push data_in in the same edge; len unchanged.
  - If len==0: enqueue only (data_out unchanged, len becomes 1). No bypass of data_in to data_out.
  - If len==8: dequeue to data_out and push data_in into the freed slot; len stays 8.
- Neither high: all state holds.
- Latency: data_out and len_out update on the same edge that samples the request; results are visible after that edge. No combinational path from inputs to outputs.
- Ordering is strict FIFO; words come out in enqueue order across pointer wrap-around.
- Inputs are sampled only at rising edges; changes between edges have no effect.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> len_out=0, data_out=0x00. Release -> still 0 until the first request.
- Fill and overflow: enqueue 0x11,0x22,...,0x99 on 9 consecutive edges -> len_out counts 1..8 and stays 8. 0x99 is discarded.
- Drain and underflow:
  - From the full queue, dequeue one per edge for 9 edges -> data_out 0x11,0x22,...,0x88; len_out 7..0.
  - 9th edge: data_out stays 0x88, len_out stays 0.
- Wrap-around:
  - Enqueue 0xA0..0xA5 (6), dequeue 4, enqueue 0xB0..0xB5 (6) -> len_out=8.
  - Draining yields 0xA4,0xA5,0xB0..0xB5.
- Simultaneous:
  - With queue {0x01,0x02}, assert both with data_in=0x03 for one edge -> data_out=0x01, len_out=2. Subsequent drain gives 0x02,0x03.
  - On an empty queue, both high with 0x55 -> len_out=1, data_out unchanged.
- Async reset mid-stream: with len_out=5, pull reset low between clock edges -> len_out and data_out go to 0 immediately. After release, enqueue 0x42 then dequeue -> data_out=0x42.
